// File: rtl/ser_arb_pkg.sv
// Shared types and constants for the 64->8 serializer arbiter.
// The optional dropped-strobe counter is enabled by defining SER_ARB_DROP_CNT_EN.
package ser_arb_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int WORD_W         = 64;
    localparam int BYTE_W         = 8;
    localparam int BYTES_PER_WORD = 8;

endpackage

// File: rtl/ser_64_8_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requesting channel
// found when searching upward from last_grant+1, wrapping at N_CH.
module rr_pick #(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] last_grant,
    output logic [CH_W-1:0] grant,
    output logic            any
);

    logic [CH_W-1:0] idx;

    // Scan N_CH positions starting just after the previous winner; first hit wins
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = CH_W'((int'(last_grant) + k) % N_CH);
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/ser_64_8_arbiter.sv
// Round-robin scheduler sharing one 64->8 serializer between N_CH word
// producers. Each channel owns a one-word holding register; the granted word
// is loaded into the serializer, its bytes are pulled one request at a time
// and forwarded downstream tagged with the owning channel.
// Optional feature: define SER_ARB_DROP_CNT_EN to add the saturating
// drop_count output (strobes lost because the channel was busy).
module ser_64_8_arbiter
    import ser_arb_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_CH-1:0]          ch_strobe,
    input  logic [N_CH*WORD_W-1:0]   ch_data,
    output logic [N_CH-1:0]          ch_busy,
    output logic                     ser_strobe_in,
    output logic [WORD_W-1:0]        ser_input_data,
    input  logic                     ser_ready,
    output logic                     ser_req_data,
    input  logic                     ser_strobe_out,
    input  logic [BYTE_W-1:0]        ser_data_out,
    input  logic                     ser_data_end,
    output logic                     out_strobe,
    output logic [BYTE_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     out_last,
    output logic                     proto_err
`ifdef SER_ARB_DROP_CNT_EN
    ,
    output logic [15:0]              drop_count
`endif
);

    state_t            state;
    logic [N_CH-1:0]   pending;
    logic [WORD_W-1:0] hold [N_CH];
    logic [CH_W-1:0]   owner;
    logic [CH_W-1:0]   last_grant;
    logic [2:0]        byte_cnt;
    logic              outstanding;

    logic [N_CH-1:0]   accept;
    logic [N_CH-1:0]   clear_mask;
    logic [CH_W-1:0]   pick_grant;
    logic              pick_any;
    logic              last_slot;

    // A strobe is taken only when the channel's holding register is empty
    assign accept    = ch_strobe & ~pending;
    assign ch_busy   = pending;
    assign last_slot = (byte_cnt == 3'(BYTES_PER_WORD - 1));

    rr_pick #(
        .N_CH (N_CH),
        .CH_W (CH_W)
    ) u_pick (
        .req        (pending),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .any        (pick_any)
    );

    // The owner's pending bit is released in LOAD, as its word moves to the serializer
    always_comb begin
        clear_mask = '0;
        if (state == LOAD) begin
            clear_mask[owner] = 1'b1;
        end
    end

    // Holding registers: data only, loaded on an accepted strobe
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CH; i++) begin
            if (accept[i]) begin
                hold[i] <= ch_data[i*WORD_W +: WORD_W];
            end
        end
    end

    // Pending flags: set on accept, cleared when the word is loaded
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending <= '0;
        end else begin
            pending <= (pending | accept) & ~clear_mask;
        end
    end

    // Scheduler FSM with registered serializer-side and downstream outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            owner          <= '0;
            last_grant     <= CH_W'(N_CH - 1);
            byte_cnt       <= '0;
            outstanding    <= 1'b0;
            ser_strobe_in  <= 1'b0;
            ser_input_data <= '0;
            ser_req_data   <= 1'b0;
            out_strobe     <= 1'b0;
            out_data       <= '0;
            out_ch         <= '0;
            out_last       <= 1'b0;
            proto_err      <= 1'b0;
        end else begin
            ser_strobe_in <= 1'b0;
            ser_req_data  <= 1'b0;
            out_strobe    <= 1'b0;
            out_last      <= 1'b0;
            case (state)
                IDLE: begin
                    // A byte with no word in flight is a serializer contract violation
                    if (ser_strobe_out) begin
                        proto_err <= 1'b1;
                    end
                    if (pick_any) begin
                        owner <= pick_grant;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (ser_strobe_out) begin
                        proto_err <= 1'b1;
                    end
                    ser_strobe_in  <= 1'b1;
                    ser_input_data <= hold[owner];
                    last_grant     <= owner;
                    byte_cnt       <= '0;
                    outstanding    <= 1'b0;
                    state          <= DRAIN;
                end
                DRAIN: begin
                    if (ser_strobe_out) begin
                        outstanding <= 1'b0;
                        out_strobe  <= 1'b1;
                        out_data    <= ser_data_out;
                        out_ch      <= owner;
                        out_last    <= ser_data_end;
                        byte_cnt    <= byte_cnt + 3'd1;
                        // Word ends on the end flag or on the eighth byte,
                        // and the two must coincide
                        if (ser_data_end || last_slot) begin
                            state <= IDLE;
                            if (ser_data_end != last_slot) begin
                                proto_err <= 1'b1;
                            end
                        end
                    end else if (ser_ready && !outstanding) begin
                        ser_req_data <= 1'b1;
                        outstanding  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SER_ARB_DROP_CNT_EN
    // Number of strobes lost this cycle across all channels
    function automatic logic [3:0] drop_sum(input logic [N_CH-1:0] hits);
        logic [3:0] s;
        s = '0;
        for (int i = 0; i < N_CH; i++) begin
            s = s + {3'b000, hits[i]};
        end
        return s;
    endfunction

    // Add that never wraps: sticks at all-ones
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Saturating count of strobes that arrived while the channel was busy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else begin
            drop_count <= sat_add16(drop_count, drop_sum(ch_strobe & pending));
        end
    end
`endif

endmodule
